// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one physical memory port between the instruction fetch unit (IFU)
//   and the load/store unit (LSU) using valid/ready handshakes. Exactly one
//   transaction is in flight at a time. When both masters request in the same
//   cycle, the LSU is granted.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     ifu_req_*/ifu_addr       IFU fetch request channel
//     ifu_resp_*               IFU response channel
//     lsu_req_*/lsu_addr/...   LSU load/store request channel
//     lsu_resp_*               LSU response channel
//     resp_rdata               read data shared by both masters, qualified by
//                              the matching *_resp_valid
//     mem_req_*/mem_addr/...   registered request to memory
//     mem_resp_*/mem_rdata     response from memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  // LSU
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  // Shared response data
  output logic [DATA_W-1:0]   resp_rdata,
  // Memory
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = IFU, 1 = LSU
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic                wen_q,   wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                owner_resp_ready;

  // Read data is a pure pass-through; the resp_valid strobes qualify it.
  assign resp_rdata = mem_rdata;

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  assign owner_resp_ready = owner_q ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The grant is suppressed while rst is high: the register update is
        // overridden by reset, so a visible ready would accept a request
        // that is then silently lost.
        lsu_req_ready = lsu_req_valid & ~rst;
        ifu_req_ready = ifu_req_valid & ~lsu_req_valid & ~rst;
        if (lsu_req_valid) begin
          owner_d = 1'b1;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          state_d = REQ;
        end else if (ifu_req_valid) begin
          owner_d = 1'b0;
          addr_d  = ifu_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = RESP;
        end
      end

      RESP: begin
        mem_resp_ready = owner_resp_ready;
        ifu_resp_valid = mem_resp_valid & ~owner_q;
        lsu_resp_valid = mem_resp_valid &  owner_q;
        if (mem_resp_valid && owner_resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the datapath registers are reset along with the control state
  // because mem_addr/mem_wen/mem_wdata/mem_wmask must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: directed scenarios followed by
//   randomized traffic against a transaction-level scoreboard and a
//   behavioural memory.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_wen;
  logic [3:0]  lsu_wmask;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid, mem_resp_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_rdata      (mem_rdata)
  );

  // Inputs change 1 time unit after the rising edge; checks happen a further
  // unit later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    ifu_req_valid  = 1'b0;
    ifu_addr       = '0;
    ifu_resp_ready = 1'b0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = '0;
    lsu_wen        = 1'b0;
    lsu_wdata      = '0;
    lsu_wmask      = '0;
    lsu_resp_ready = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    settle();
    total_cnt++;
    if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready} !== 6'b0)
      $display("FAIL reset_handshakes: got %b want 000000",
               {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_wdata, mem_wen, mem_wmask} !== 69'b0)
      $display("FAIL reset_mem_fields: addr %h wdata %h wen %b wmask %h, want all 0",
               mem_addr, mem_wdata, mem_wen, mem_wmask);
    else pass_cnt++;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ifu_only();
    // cycle 0: grant
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    settle();
    total_cnt++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10)
      $display("FAIL ifu_only_grant: got ifu/lsu ready %b want 10", {ifu_req_ready, lsu_req_ready});
    else pass_cnt++;
    tick();
    // cycle 1: request on the memory port, accepted immediately
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    total_cnt++;
    if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, ifu_resp_valid} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0, 1'b0})
      $display("FAIL ifu_only_req: valid %b addr %h wen %b wmask %h resp %b want 1 80000000 0 0 0",
               mem_req_valid, mem_addr, mem_wen, mem_wmask, ifu_resp_valid);
    else pass_cnt++;
    tick();
    // cycle 2: response
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0413;
    ifu_resp_ready = 1'b1;
    settle();
    total_cnt++;
    if ({ifu_resp_valid, lsu_resp_valid, mem_resp_ready, resp_rdata} !== {1'b1, 1'b0, 1'b1, 32'h0000_0413})
      $display("FAIL ifu_only_resp: ifu_v %b lsu_v %b mem_rr %b rdata %h want 1 0 1 00000413",
               ifu_resp_valid, lsu_resp_valid, mem_resp_ready, resp_rdata);
    else pass_cnt++;
    tick();
    drive_idle();
    settle();
    total_cnt++;
    if ({mem_req_valid, ifu_resp_valid, mem_resp_ready} !== 3'b000)
      $display("FAIL ifu_only_done: req_v %b resp_v %b mem_rr %b want 000",
               mem_req_valid, ifu_resp_valid, mem_resp_ready);
    else pass_cnt++;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_conflict();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0010;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 4'hF;
    settle();
    total_cnt++;
    if ({lsu_req_ready, ifu_req_ready} !== 2'b10)
      $display("FAIL conflict_grant: lsu/ifu ready %b want 10", {lsu_req_ready, ifu_req_ready});
    else pass_cnt++;
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    total_cnt++;
    if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready} !==
        {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0})
      $display("FAIL conflict_store_req: v %b addr %h wen %b wdata %h wmask %h ifu_rdy %b want 1 80001000 1 deadbeef f 0",
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready);
    else pass_cnt++;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    lsu_resp_ready = 1'b1;
    settle();
    total_cnt++;
    if ({lsu_resp_valid, ifu_resp_valid, ifu_req_ready} !== 3'b100)
      $display("FAIL conflict_store_ack: lsu_v %b ifu_v %b ifu_rdy %b want 100",
               lsu_resp_valid, ifu_resp_valid, ifu_req_ready);
    else pass_cnt++;
    tick();
    mem_resp_valid = 1'b0;
    lsu_resp_ready = 1'b0;
    settle();
    total_cnt++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10)
      $display("FAIL conflict_ifu_grant: ifu/lsu ready %b want 10", {ifu_req_ready, lsu_req_ready});
    else pass_cnt++;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    total_cnt++;
    if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0010, 1'b0, 4'h0})
      $display("FAIL conflict_ifu_req: v %b addr %h wen %b wmask %h want 1 80000010 0 0",
               mem_req_valid, mem_addr, mem_wen, mem_wmask);
    else pass_cnt++;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    ifu_resp_ready = 1'b1;
    tick();
    drive_idle();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    int hs_cnt = 0;
    int bad_stable = 0;
    int bad_grant = 0;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2040;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hA5A5_0F0F;
    lsu_wmask     = 4'h6;
    tick();
    lsu_req_valid = 1'b0;
    lsu_addr      = 32'h0;
    lsu_wdata     = 32'h0;
    ifu_req_valid = 1'b1;        // competing request held throughout
    ifu_addr      = 32'h8000_0100;
    for (int c = 0; c < 8; c++) begin
      mem_req_ready  = (c == 3);
      mem_resp_valid = (c >= 4);
      mem_rdata      = $urandom;
      lsu_resp_ready = (c >= 6);
      settle();
      if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== {32'h8000_2040, 1'b1, 32'hA5A5_0F0F, 4'h6})
        bad_stable++;
      if (c <= 3 && mem_req_valid !== 1'b1) bad_stable++;
      if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) bad_grant++;
      if (lsu_resp_valid && lsu_resp_ready) hs_cnt++;
      if (c == 6) break;
      tick();
    end
    total_cnt++;
    if (bad_stable != 0) $display("FAIL backpressure_stable: %0d unstable cycles want 0", bad_stable);
    else pass_cnt++;
    total_cnt++;
    if (bad_grant != 0) $display("FAIL backpressure_no_grant: %0d early grants want 0", bad_grant);
    else pass_cnt++;
    tick();
    mem_resp_valid = 1'b0;
    lsu_resp_ready = 1'b0;
    settle();
    if (lsu_resp_valid && lsu_resp_ready) hs_cnt++;
    total_cnt++;
    if (hs_cnt != 1) $display("FAIL backpressure_one_resp: %0d handshakes want 1", hs_cnt);
    else pass_cnt++;
    total_cnt++;
    if (ifu_req_ready !== 1'b1) $display("FAIL backpressure_next_grant: ifu_rdy %b want 1", ifu_req_ready);
    else pass_cnt++;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    ifu_resp_ready = 1'b1;
    tick();
    drive_idle();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_in_resp();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0200;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;        // now waiting for a response that never comes
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    total_cnt++;
    if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready} !== 6'b0)
      $display("FAIL rst_in_resp_outputs: got %b want 000000",
               {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_resp_ready});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 32'h0) $display("FAIL rst_in_resp_addr: got %h want 00000000", mem_addr);
    else pass_cnt++;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0300;
    settle();
    total_cnt++;
    if (ifu_req_ready !== 1'b1) $display("FAIL rst_in_resp_regrant: ifu_rdy %b want 1", ifu_req_ready);
    else pass_cnt++;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    total_cnt++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0300})
      $display("FAIL rst_in_resp_req: v %b addr %h want 1 80000300", mem_req_valid, mem_addr);
    else pass_cnt++;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    ifu_resp_ready = 1'b1;
    tick();
    drive_idle();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [31:0] addrs [2];
    addrs[0] = 32'h8000_0004;
    addrs[1] = 32'h8000_0008;
    for (int k = 0; k < 2; k++) begin
      lsu_req_valid = 1'b1;
      lsu_addr      = addrs[k];
      lsu_wen       = 1'b0;
      settle();
      total_cnt++;
      if (lsu_req_ready !== 1'b1) $display("FAIL b2b_grant%0d: lsu_rdy %b want 1", k, lsu_req_ready);
      else pass_cnt++;
      tick();
      // Master keeps the next request presented right away.
      if (k == 0) lsu_addr = addrs[1];
      else        lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      settle();
      total_cnt++;
      if ({mem_req_valid, mem_addr, lsu_req_ready} !== {1'b1, addrs[k], 1'b0})
        $display("FAIL b2b_req%0d: v %b addr %h lsu_rdy %b want 1 %h 0",
                 k, mem_req_valid, mem_addr, lsu_req_ready, addrs[k]);
      else pass_cnt++;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = mem_addr;   // memory echoes the address
      lsu_resp_ready = 1'b1;
      settle();
      total_cnt++;
      if ({lsu_resp_valid, resp_rdata, lsu_req_ready} !== {1'b1, addrs[k], 1'b0})
        $display("FAIL b2b_resp%0d: v %b rdata %h lsu_rdy %b want 1 %h 0",
                 k, lsu_resp_valid, resp_rdata, lsu_req_ready, addrs[k]);
      else pass_cnt++;
      tick();
      mem_resp_valid = 1'b0;
      lsu_resp_ready = 1'b0;
    end
    drive_idle();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Random traffic. The scoreboard holds accepted transactions with the data a
  // load must return, computed from an architectural memory image updated at
  // grant time. The memory model keeps its own image, updated only from what
  // appears on the mem_* port.
  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] arch_mem [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];
  bit          ifu_hs, lsu_hs, mem_busy;
  int          mem_delay;
  logic [31:0] mem_data;
  int          n_grant, n_resp, rnd_fail;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 + ({28'd0, 4'($urandom_range(0, 15))} << 2);
  endfunction

  task automatic rand_cycle(input bit gen);
    txn_t t;
    logic [31:0] a;
    bit r_ifu, r_lsu, m_hs;
    // Masters: hold a request until accepted, then optionally issue another.
    if (ifu_hs) ifu_req_valid = 1'b0;
    if (lsu_hs) lsu_req_valid = 1'b0;
    if (gen && !ifu_req_valid && $urandom_range(0, 2) == 0) begin
      ifu_req_valid = 1'b1;
      ifu_addr      = rand_addr();
    end
    if (gen && !lsu_req_valid && $urandom_range(0, 2) == 0) begin
      lsu_req_valid = 1'b1;
      lsu_addr      = rand_addr();
      lsu_wen       = 1'($urandom_range(0, 1));
      lsu_wdata     = $urandom;
      lsu_wmask     = 4'($urandom_range(0, 15));
    end
    ifu_resp_ready = ($urandom_range(0, 3) != 0);
    lsu_resp_ready = ($urandom_range(0, 3) != 0);
    mem_req_ready  = ($urandom_range(0, 2) != 0);
    if (mem_busy && mem_delay > 0) mem_delay--;
    mem_resp_valid = mem_busy && (mem_delay == 0);
    mem_rdata      = mem_resp_valid ? mem_data : $urandom;
    settle();

    ifu_hs = ifu_req_valid && ifu_req_ready;
    lsu_hs = lsu_req_valid && lsu_req_ready;
    if (ifu_req_valid && lsu_req_valid) begin
      total_cnt++;
      if (ifu_req_ready !== 1'b0) begin
        $display("FAIL rnd_priority: ifu_rdy %b while lsu requesting want 0", ifu_req_ready);
        rnd_fail++;
      end else pass_cnt++;
    end
    if (ifu_hs || lsu_hs) begin
      total_cnt++;
      if (sb.size() != 0 || (ifu_hs && lsu_hs)) begin
        $display("FAIL rnd_one_outstanding: grant with %0d in flight, ifu_hs %b lsu_hs %b",
                 sb.size(), ifu_hs, lsu_hs);
        rnd_fail++;
      end else pass_cnt++;
      t.lsu   = lsu_hs;
      t.addr  = lsu_hs ? lsu_addr : ifu_addr;
      t.wen   = lsu_hs && lsu_wen;
      t.wdata = lsu_hs ? lsu_wdata : 32'h0;
      t.wmask = lsu_hs ? lsu_wmask : 4'h0;
      if (!arch_mem.exists(t.addr)) arch_mem[t.addr] = ~t.addr;
      t.exp = arch_mem[t.addr];
      if (t.wen) arch_mem[t.addr] = merge(arch_mem[t.addr], t.wdata, t.wmask);
      sb.push_back(t);
      n_grant++;
    end

    if (mem_req_valid && mem_req_ready) begin
      total_cnt++;
      if (sb.size() == 0 || mem_busy) begin
        $display("FAIL rnd_mem_req: unexpected request addr %h (sb %0d busy %b)", mem_addr, sb.size(), mem_busy);
        rnd_fail++;
      end else if ({mem_addr, mem_wen, mem_wmask} !== {sb[0].addr, sb[0].wen, sb[0].wmask} ||
                   (sb[0].wen && mem_wdata !== sb[0].wdata)) begin
        $display("FAIL rnd_mem_fields: got %h/%b/%h/%h want %h/%b/%h/%h", mem_addr, mem_wen, mem_wmask,
                 mem_wdata, sb[0].addr, sb[0].wen, sb[0].wmask, sb[0].wdata);
        rnd_fail++;
      end else pass_cnt++;
      a = mem_addr;
      if (!phys_mem.exists(a)) phys_mem[a] = ~a;
      mem_data = mem_wen ? $urandom : phys_mem[a];
      if (mem_wen) phys_mem[a] = merge(phys_mem[a], mem_wdata, mem_wmask);
      mem_busy  = 1'b1;
      mem_delay = $urandom_range(0, 3);
    end

    r_ifu = ifu_resp_valid && ifu_resp_ready;
    r_lsu = lsu_resp_valid && lsu_resp_ready;
    m_hs  = mem_resp_valid && mem_resp_ready;
    if (r_ifu || r_lsu || m_hs) begin
      total_cnt++;
      if ((r_ifu && r_lsu) || ((r_ifu || r_lsu) != m_hs) || sb.size() == 0) begin
        $display("FAIL rnd_resp_handshake: ifu %b lsu %b mem %b sb %0d", r_ifu, r_lsu, m_hs, sb.size());
        rnd_fail++;
      end else if (r_lsu != sb[0].lsu) begin
        $display("FAIL rnd_resp_route: to lsu %b want lsu %b", r_lsu, sb[0].lsu);
        rnd_fail++;
      end else if (!sb[0].wen && resp_rdata !== sb[0].exp) begin
        $display("FAIL rnd_resp_data: addr %h got %h want %h", sb[0].addr, resp_rdata, sb[0].exp);
        rnd_fail++;
      end else pass_cnt++;
      if (sb.size() != 0) void'(sb.pop_front());
      if (m_hs) mem_busy = 1'b0;
      n_resp++;
    end
    tick();
  endtask

  task automatic test_random();
    int budget;
    ifu_hs = 0; lsu_hs = 0; mem_busy = 0; mem_delay = 0;
    n_grant = 0; n_resp = 0; rnd_fail = 0;
    for (int c = 0; c < 10000; c++) begin
      rand_cycle(1'b1);
      if (rnd_fail > 20) break;
    end
    budget = 500;
    while (budget > 0 && (sb.size() != 0 || ifu_req_valid || lsu_req_valid || mem_busy)) begin
      rand_cycle(1'b0);
      budget--;
    end
    total_cnt++;
    if (budget == 0 || sb.size() != 0 || n_grant != n_resp || n_grant < 100)
      $display("FAIL rnd_drain: grants %0d responses %0d in flight %0d budget left %0d",
               n_grant, n_resp, sb.size(), budget);
    else pass_cnt++;
    drive_idle();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_ifu_only();
    test_conflict();
    test_backpressure();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
